// File: rtl/ysyx_cdb_pkg.sv
// Shared CDB entry type and round-robin helper for the EXU completion buffer.
// Optional feature macro: YSYX_CDB_BYPASS_EN (consumed by ysyx_exu_cdb).
`ifndef YSYX_XLEN
`define YSYX_XLEN 32
`endif
`ifndef YSYX_ROB_SIZE
`define YSYX_ROB_SIZE 16
`endif

package ysyx_cdb_pkg;

   localparam int unsigned CDB_XLEN = `YSYX_XLEN;
   localparam int unsigned CDB_ROBW = $clog2(`YSYX_ROB_SIZE) + 1;

   typedef struct packed {
      logic [CDB_ROBW-1:0] dest;
      logic [CDB_XLEN-1:0] result;
      logic [CDB_XLEN-1:0] npc;
      logic                trap;
      logic [CDB_XLEN-1:0] cause;
   } cdb_entry_t;

   function automatic int unsigned rr_next(input int unsigned g,
                                           input int unsigned n);
      return (g + 1 >= n) ? 0 : g + 1;
   endfunction

endpackage

// File: rtl/ysyx_cdb_fifo.sv
// Single-channel in-order completion FIFO holding cdb_entry_t results.
// Pointers wrap naturally since DEPTH is a power of two.
module ysyx_cdb_fifo
   import ysyx_cdb_pkg::*;
#(
   parameter  int unsigned DEPTH = 2,
   localparam int unsigned AW    = $clog2(DEPTH)
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       flush_i,
   input  logic       push_i,
   input  cdb_entry_t din_i,
   input  logic       pop_i,
   output logic [AW:0] count_o,
   output cdb_entry_t head_o
);

   cdb_entry_t    mem_q [DEPTH];
   logic [AW-1:0] wptr_q, wptr_d;
   logic [AW-1:0] rptr_q, rptr_d;
   logic [AW:0]   cnt_q, cnt_d;

   always_comb begin
      wptr_d = wptr_q + AW'(push_i);
      rptr_d = rptr_q + AW'(pop_i);
      cnt_d  = cnt_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
   end

   always_ff @(posedge clock) begin
      if (reset || flush_i) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         cnt_q  <= cnt_d;
      end
   end

   // Payload storage needs no reset; validity lives in cnt_q.
   always_ff @(posedge clock) begin
      if (push_i && !reset && !flush_i) begin
         mem_q[wptr_q] <= din_i;
      end
   end

   assign count_o = cnt_q;
   assign head_o  = mem_q[rptr_q];

endmodule

// File: rtl/ysyx_exu_cdb.sv
// Multi-channel EXU completion buffer with round-robin CDB broadcast.
// Optional macro YSYX_CDB_BYPASS_EN: same-cycle bypass when all FIFOs are empty.
`ifndef YSYX_XLEN
`define YSYX_XLEN 32
`endif
`ifndef YSYX_ROB_SIZE
`define YSYX_ROB_SIZE 16
`endif

module ysyx_exu_cdb
   import ysyx_cdb_pkg::*;
#(
   parameter  int unsigned NCH   = 3,
   parameter  int unsigned DEPTH = 2,
   parameter  int unsigned ROBW  = $clog2(`YSYX_ROB_SIZE) + 1,
   parameter  int unsigned XLEN  = `YSYX_XLEN,
   localparam int unsigned CHW   = $clog2(NCH),
   localparam int unsigned AW    = $clog2(DEPTH)
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                flush,
   input  logic [NCH-1:0]      in_valid,
   output logic [NCH-1:0]      in_ready,
   input  logic [NCH*ROBW-1:0] in_dest,
   input  logic [NCH*XLEN-1:0] in_result,
   input  logic [NCH*XLEN-1:0] in_npc,
   input  logic [NCH-1:0]      in_trap,
   input  logic [NCH*XLEN-1:0] in_cause,
   output logic                cdb_valid,
   input  logic                cdb_ready,
   output logic [ROBW-1:0]     cdb_dest,
   output logic [XLEN-1:0]     cdb_result,
   output logic [XLEN-1:0]     cdb_npc,
   output logic                cdb_trap,
   output logic [XLEN-1:0]     cdb_cause,
   output logic [CHW-1:0]      cdb_ch
);

   logic [NCH-1:0] push, pop, nonempty, req;
   cdb_entry_t     in_ent [NCH];
   cdb_entry_t     head   [NCH];
   logic [AW:0]    cnt    [NCH];
   logic [CHW-1:0] rr_q, rr_d, lock_ch_q, lock_ch_d, grant;
   logic           lock_v_q, lock_v_d, found, byp, fire, kill;
   cdb_entry_t     sel;

   assign kill = reset || flush;

   for (genvar i = 0; i < NCH; i++) begin : g_ch
      assign in_ent[i].dest   = in_dest[i*ROBW +: ROBW];
      assign in_ent[i].result = in_result[i*XLEN +: XLEN];
      assign in_ent[i].npc    = in_npc[i*XLEN +: XLEN];
      assign in_ent[i].trap   = in_trap[i];
      assign in_ent[i].cause  = in_cause[i*XLEN +: XLEN];
      assign nonempty[i] = (cnt[i] != '0);
      assign in_ready[i] = (cnt[i] != (AW+1)'(DEPTH)) && !kill;
      assign push[i] = in_valid[i] && in_ready[i]
                    && !(byp && fire && grant == CHW'(i));
      assign pop[i]  = fire && !byp && grant == CHW'(i);

      ysyx_cdb_fifo #(.DEPTH(DEPTH)) u_fifo (
         .clock   (clock),
         .reset   (reset),
         .flush_i (flush),
         .push_i  (push[i]),
         .din_i   (in_ent[i]),
         .pop_i   (pop[i]),
         .count_o (cnt[i]),
         .head_o  (head[i])
      );
   end

`ifdef YSYX_CDB_BYPASS_EN
   assign byp = (nonempty == '0) && !lock_v_q;
   assign req = byp ? in_valid : nonempty;
`else
   assign byp = 1'b0;
   assign req = nonempty;
`endif

   // A held lock pins the grant so a stalled broadcast never changes payload.
   always_comb begin
      int unsigned idx;
      idx   = 0;
      found = lock_v_q;
      grant = lock_v_q ? lock_ch_q : '0;
      if (!lock_v_q) begin
         for (int k = 0; k < NCH; k++) begin
            idx = (32'(rr_q) + k) % NCH;
            if (!found && req[idx]) begin
               found = 1'b1;
               grant = CHW'(idx);
            end
         end
      end
   end

   assign cdb_valid = found && !kill;
   assign fire      = cdb_valid && cdb_ready;
   assign sel       = byp ? in_ent[grant] : head[grant];

   always_comb begin
      cdb_dest   = '0;
      cdb_result = '0;
      cdb_npc    = '0;
      cdb_trap   = 1'b0;
      cdb_cause  = '0;
      cdb_ch     = '0;
      if (cdb_valid) begin
         cdb_dest   = sel.dest;
         cdb_result = sel.result;
         cdb_npc    = sel.npc;
         cdb_trap   = sel.trap;
         cdb_cause  = sel.cause;
         cdb_ch     = grant;
      end
   end

   assign rr_d      = fire ? CHW'(rr_next(32'(grant), NCH)) : rr_q;
   assign lock_v_d  = cdb_valid && !cdb_ready;
   assign lock_ch_d = grant;

   always_ff @(posedge clock) begin
      if (kill) begin
         rr_q      <= '0;
         lock_v_q  <= 1'b0;
         lock_ch_q <= '0;
      end else begin
         rr_q      <= rr_d;
         lock_v_q  <= lock_v_d;
         lock_ch_q <= lock_ch_d;
      end
   end

endmodule

// File: tb/tb_ysyx_exu_cdb.sv
// Directed self-checking bench for ysyx_exu_cdb (NCH=3, DEPTH=2).
// Inputs change 1 time unit after posedge; outputs are checked 1 unit later.
module tb_ysyx_exu_cdb;

   localparam int NCH = 3;
   localparam int DEPTH = 2;
   localparam int ROBW = 5;
   localparam int XLEN = 32;

   logic clock = 1'b0;
   logic reset, flush, cdb_ready;
   logic [NCH-1:0] in_valid, in_ready, in_trap;
   logic [NCH*ROBW-1:0] in_dest;
   logic [NCH*XLEN-1:0] in_result, in_npc, in_cause;
   logic cdb_valid, cdb_trap;
   logic [ROBW-1:0] cdb_dest;
   logic [XLEN-1:0] cdb_result, cdb_npc, cdb_cause;
   logic [1:0] cdb_ch;

   int checks = 0;
   int failures = 0;

   int exp_rdy[7]  = '{7, 7, 1, 2, 4, 1, 2};
   int exp_ch[13]  = '{0, 0, 1, 2, 0, 1, 2, 0, 1, 2, 0, 1, 0};
   int exp_res[13] = '{0, 'h00, 'h10, 'h20, 'h01, 'h11, 'h21,
                       'h02, 'h13, 'h24, 'h05, 'h16, 0};

   always #5 clock = ~clock;

   ysyx_exu_cdb #(
      .NCH(NCH), .DEPTH(DEPTH), .ROBW(ROBW), .XLEN(XLEN)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .flush      (flush),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_dest    (in_dest),
      .in_result  (in_result),
      .in_npc     (in_npc),
      .in_trap    (in_trap),
      .in_cause   (in_cause),
      .cdb_valid  (cdb_valid),
      .cdb_ready  (cdb_ready),
      .cdb_dest   (cdb_dest),
      .cdb_result (cdb_result),
      .cdb_npc    (cdb_npc),
      .cdb_trap   (cdb_trap),
      .cdb_cause  (cdb_cause),
      .cdb_ch     (cdb_ch)
   );

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic idle();
      in_valid  = '0;
      in_trap   = '0;
      in_dest   = '0;
      in_result = '0;
      in_npc    = '0;
      in_cause  = '0;
   endtask

   task automatic set_ch(input int ch, input logic [4:0] d,
                         input logic [31:0] r, input logic t,
                         input logic [31:0] c);
      in_valid[ch]            = 1'b1;
      in_dest[ch*ROBW +: ROBW] = d;
      in_result[ch*XLEN +: XLEN] = r;
      in_npc[ch*XLEN +: XLEN]  = r + 32'd4;
      in_trap[ch]             = t;
      in_cause[ch*XLEN +: XLEN] = c;
   endtask

   initial begin
      reset = 1'b1;
      flush = 1'b0;
      cdb_ready = 1'b0;
      idle();
      step();
      step();
      chk("rst_in_ready", in_ready, 0);
      chk("rst_valid", cdb_valid, 0);
      chk("rst_ch", cdb_ch, 0);
      chk("rst_dest", cdb_dest, 0);
      chk("rst_result", cdb_result, 0);
      reset = 1'b0;
      step();
      chk("idle_valid", cdb_valid, 0);
      chk("idle_in_ready", in_ready, 7);

      // single push on ch1
      set_ch(1, 5'd5, 32'h1234, 1'b0, 32'd0);
      cdb_ready = 1'b1;
      #1;
`ifndef YSYX_CDB_BYPASS_EN
      chk("push_no_comb", cdb_valid, 0);
`endif
      step();
      idle();
      #1;
      chk("push_valid", cdb_valid, 1);
      chk("push_ch", cdb_ch, 1);
      chk("push_dest", cdb_dest, 5);
      chk("push_result", cdb_result, 32'h1234);
      chk("push_npc", cdb_npc, 32'h1238);
      step();
      chk("push_drained", cdb_valid, 0);
      flush = 1'b1;
      #1;
      chk("flush_in_ready", in_ready, 0);
      step();
      flush = 1'b0;

      // all channels push every cycle, then drain
      for (int t = 0; t < 13; t++) begin
         idle();
         if (t <= 6) begin
            for (int c = 0; c < NCH; c++) begin
               set_ch(c, 5'(t), 32'(16 * c + t), 1'b0, 32'd0);
            end
         end
         #1;
         if (t <= 6) chk($sformatf("rr_rdy%0d", t), in_ready, exp_rdy[t]);
         chk($sformatf("rr_v%0d", t), cdb_valid, (t >= 1 && t <= 11));
         if (t >= 1 && t <= 11) begin
            chk($sformatf("rr_ch%0d", t), cdb_ch, exp_ch[t]);
            chk($sformatf("rr_res%0d", t), cdb_result, exp_res[t]);
         end
         step();
      end
      idle();

      // back-pressure hold with lock
      cdb_ready = 1'b0;
      set_ch(0, 5'd7, 32'h77, 1'b0, 32'd0);
      step();
      idle();
      for (int k = 0; k < 4; k++) begin
         if (k == 1) set_ch(2, 5'd9, 32'h99, 1'b0, 32'd0);
         #1;
         chk($sformatf("hold_v%0d", k), cdb_valid, 1);
         chk($sformatf("hold_ch%0d", k), cdb_ch, 0);
         chk($sformatf("hold_dest%0d", k), cdb_dest, 7);
         step();
         idle();
      end
      cdb_ready = 1'b1;
      #1;
      chk("hold_fire_dest", cdb_dest, 7);
      step();
      chk("hold_next_ch", cdb_ch, 2);
      chk("hold_next_dest", cdb_dest, 9);
      step();
      chk("hold_empty", cdb_valid, 0);

      // fill ch1, then flush with a ch0 push
      cdb_ready = 1'b0;
      set_ch(1, 5'd1, 32'h1, 1'b0, 32'd0);
      step();
      idle();
      set_ch(1, 5'd2, 32'h2, 1'b0, 32'd0);
      step();
      idle();
      chk("fl_full", in_ready, 5);
      cdb_ready = 1'b1;
      #1;
      chk("fl_ch1", cdb_ch, 1);
      step();
      cdb_ready = 1'b0;
      set_ch(1, 5'd3, 32'h3, 1'b0, 32'd0);
      step();
      idle();
      flush = 1'b1;
      cdb_ready = 1'b1;
      set_ch(0, 5'd11, 32'hb, 1'b0, 32'd0);
      #1;
      chk("fl_cyc_valid", cdb_valid, 0);
      chk("fl_cyc_ready", in_ready, 0);
      step();
      flush = 1'b0;
      cdb_ready = 1'b0;
      idle();
      #1;
      chk("fl_after_valid", cdb_valid, 0);
      chk("fl_after_ready", in_ready, 7);
      for (int c = 0; c < NCH; c++) set_ch(c, 5'(c), 32'(c), 1'b0, 32'd0);
      step();
      idle();
      chk("fl_rr_zero", cdb_ch, 0);
      flush = 1'b1;
      step();
      flush = 1'b0;

`ifdef YSYX_CDB_BYPASS_EN
      cdb_ready = 1'b1;
      set_ch(2, 5'd3, 32'h3, 1'b0, 32'd0);
      #1;
      chk("byp_valid", cdb_valid, 1);
      chk("byp_ch", cdb_ch, 2);
      chk("byp_dest", cdb_dest, 3);
      step();
      idle();
      chk("byp_not_queued", cdb_valid, 0);
`endif

      // trap payload
      cdb_ready = 1'b1;
      set_ch(0, 5'd4, 32'h40, 1'b1, 32'd2);
      step();
      idle();
      chk("trap_flag", cdb_trap, 1);
      chk("trap_cause", cdb_cause, 2);
      chk("trap_dest", cdb_dest, 4);
      step();
      chk("trap_zero_valid", cdb_valid, 0);
      chk("trap_zero_flag", cdb_trap, 0);

      // reset mid-operation discards entries
      cdb_ready = 1'b0;
      set_ch(2, 5'd6, 32'h6, 1'b0, 32'd0);
      step();
      idle();
      chk("mrst_pre", cdb_valid, 1);
      reset = 1'b1;
      #1;
      chk("mrst_valid", cdb_valid, 0);
      chk("mrst_ready", in_ready, 0);
      step();
      reset = 1'b0;
      #1;
      chk("mrst_after", cdb_valid, 0);
      chk("mrst_after_rdy", in_ready, 7);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ysyx_exu_cdb.md
# ysyx_exu_cdb

Multi-channel completion buffer and arbiter between the execution units and the ROB/writeback stage. It generalises the single EXU→WBU result bundle to NCH independent execution channels. Each channel has its own DEPTH-entry FIFO, and one result per cycle is broadcast on the common data bus (CDB) under round-robin arbitration. It absorbs writeback back-pressure and is cleared on pipeline flush.

## Interface
Parameters:
- NCH, 3: number of execution channels (≥2).
- DEPTH, 2: entries per channel FIFO (power of two, ≥2).
- ROBW, $clog2(`YSYX_ROB_SIZE)+1: ROB tag width.
- XLEN, `YSYX_XLEN: data width.

Ports. Reset is synchronous, active-high, on `clock`; `reset` is the reset input. Per-channel inputs are flattened with channel i at bits [i*W +: W].
- clock  in  1  system clock
- reset  in  1  synchronous active-high reset
- flush  in  1  squash all buffered results
- in_valid  in  NCH  channel i offers a result
- in_ready  out  NCH  channel i FIFO can accept
- in_dest  in  NCH*ROBW  ROB tag
- in_result  in  NCH*XLEN  result value
- in_npc  in  NCH*XLEN  resolved next pc
- in_trap  in  NCH  exception flag
- in_cause  in  NCH*XLEN  exception cause
- cdb_valid  out  1  broadcast valid
- cdb_ready  in  1  ROB accepts broadcast
- cdb_dest, cdb_result, cdb_npc, cdb_trap, cdb_cause  out  ROBW/XLEN/XLEN/1/XLEN  selected entry
- cdb_ch  out  $clog2(NCH)  source channel of broadcast

## Operation
- Enqueue on channel i when in_valid[i] && in_ready[i]. Dequeue of the granted channel happens when cdb_valid && cdb_ready.
- in_ready[i] = (count[i] != DEPTH) && !reset && !flush. It does not depend on in_valid or cdb_ready.
- A channel can enqueue and dequeue in the same cycle. When the FIFO is full, this still yields in_ready=0: no full-FIFO pass-through.
- Arbitration is round-robin over non-empty channels, starting at rr_ptr.
- On a fire, rr_ptr becomes grant+1 modulo NCH. With no fire, rr_ptr holds, so the grant is stable while cdb_ready=0 unless a lower-priority channel's entry is the only one.
  - Required: once cdb_valid rises with channel g, the payload is held until it fires, even if another channel becomes non-empty.
  - Implementation: a lock register holds g while cdb_valid && !cdb_ready.
- Each FIFO is in-order. Pointers wrap modulo DEPTH, and the count is $clog2(DEPTH)+1 bits wide.
- Flush: all counts, pointers and the lock clear on the next edge, and rr_ptr resets to 0. In the flush cycle cdb_valid=0 and in_valid is ignored.
- Reset has the same effect as flush. Reset mid-operation discards all entries.
- The CDB payload is combinational from the granted head entry. X-free: zeros when cdb_valid=0.

## Timing
- Reset values: cdb_valid=0, all cdb_* payloads 0, cdb_ch=0, in_ready=0 during the reset cycle and all-ones the cycle after.
- Base latency: a result enqueued in cycle N can appear on the CDB in cycle N+1.
- Throughput: 1 broadcast per cycle. Sustained aggregate input above 1/cycle back-pressures via in_ready.
- Simultaneous flush with enqueue: the enqueue is dropped. Simultaneous flush with cdb_ready: no fire.

## Configuration
- YSYX_CDB_BYPASS_EN defined: when every FIFO is empty, no lock is held, and some in_valid[i]=1, the round-robin winner among the valid inputs drives the CDB combinationally in the same cycle (latency 0).
  - If it fires, it is not enqueued.
  - If it does not fire, it is enqueued normally and the lock takes it.
- Undefined: no combinational path from in_* to cdb_*, and latency is ≥1.

## Structure
- Package ysyx_cdb_pkg holds:
  - typedef cdb_entry_t: a packed struct of dest, result, npc, trap, cause, widths from `YSYX_XLEN and `YSYX_ROB_SIZE.
  - The round-robin next-pointer function.
- One sub-module, ysyx_cdb_fifo: a single-channel DEPTH-entry FIFO of cdb_entry_t with push, pop, flush, count, and head outputs. It is instantiated NCH times via generate.

## Test plan
- Reset, then idle: cdb_valid=0 and in_ready=3'b111 one cycle after reset falls. With the macro off, one push on ch1 (dest=5, result=0x1234) gives cdb_valid=1, cdb_ch=1, cdb_dest=5 the next cycle.
- All three channels push every cycle with cdb_ready=1: the grant sequence is 0,1,2,0,1,2. Each channel sees in_ready=0 after DEPTH unserved entries, and no result is lost or reordered per channel.
- cdb_ready=0 for 4 cycles while ch0 holds dest=7, then ch2 pushes: the CDB stays on ch0/dest=7 until it fires. ch2 is granted next.
- Fill ch1 to DEPTH=2, then assert flush with a push on ch0: the next cycle all FIFOs are empty, cdb_valid=0, rr_ptr=0, and the ch0 push is absent.
- With YSYX_CDB_BYPASS_EN, empty FIFOs, and ch2 pushing dest=3 with cdb_ready=1: a same-cycle broadcast with cdb_ch=2, and count[2] stays 0.
- Push with in_trap=1, cause=2 on ch0: cdb_trap=1 and cdb_cause=2 are broadcast unchanged.
